// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and constants for the UART block loader
// Contents: loader state enum, abort cause codes, header field position helpers.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_ZERO_COUNT = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd2;
    localparam logic [2:0] ERR_OVERRUN    = 3'd3;
    localparam logic [2:0] ERR_CHECKSUM   = 3'd4;

    // Header word: base address in the low ADDR_W bits, word count right above it.
    localparam int HDR_ADDR_LSB = 0;

    function automatic int hdr_cnt_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int hdr_cnt_msb(input int addr_w, input int cnt_w);
        return addr_w + cnt_w - 1;
    endfunction

endpackage

// File: rtl/uart_block_loader_if.sv
// rtl/uart_block_loader_if.sv - word input, memory write port and status bundle of the loader
// Signals: iWordAvailable/iUartRx32 from the packer, oMemWriteEnable/oMemAddress/oMemData/iMemAck
// towards the memory write mux, oBusy/oDone/oError/oErrorCode status.
// Modports: master = host/packer/memory side, slave = loader side.
interface uart_block_loader_if #(
    parameter int ADDR_W = 16
);
    logic              iWordAvailable;
    logic [31:0]       iUartRx32;
    logic              oMemWriteEnable;
    logic [ADDR_W-1:0] oMemAddress;
    logic [31:0]       oMemData;
    logic              iMemAck;
    logic              oBusy;
    logic              oDone;
    logic              oError;
    logic [2:0]        oErrorCode;

    modport master (
        output iWordAvailable, iUartRx32, iMemAck,
        input  oMemWriteEnable, oMemAddress, oMemData, oBusy, oDone, oError, oErrorCode
    );

    modport slave (
        input  iWordAvailable, iUartRx32, iMemAck,
        output oMemWriteEnable, oMemAddress, oMemData, oBusy, oDone, oError, oErrorCode
    );
endinterface

// File: rtl/uart_loader_timeout.sv
// rtl/uart_loader_timeout.sv - saturating idle counter for the loader
// Ports: clk, rst (async active-high), clear_i (restart from 0, wins over enable_i),
// enable_i (count this cycle), expired_o (counter has reached TIMEOUT_CYCLES).
module uart_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q, count_d;

    // Holds at LIMIT so a long stall cannot wrap back into the "alive" range.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);
endmodule

// File: rtl/uart_block_loader.sv
// rtl/uart_block_loader.sv - header-driven bulk loader from UART packer words into memory
// Ports: iClock, iReset (async active-high), bus (uart_block_loader_if.slave): packer words in,
// held write request out until iMemAck, busy/done/error status.
// Optional feature: define UART_LOADER_CHECKSUM_EN to require a trailer word equal to the
// 32-bit wrap-around sum of the payload before signalling done.
module uart_block_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 iClock,
    input  logic                 iReset,
    uart_block_loader_if.slave   bus
);
    localparam int CNT_LSB = hdr_cnt_lsb(ADDR_W);
    localparam int CNT_MSB = hdr_cnt_msb(ADDR_W, CNT_W);

    state_e              state_q, state_d;
    logic                avail_q;
    logic                buf_full_q, buf_full_d;
    logic [31:0]         buf_q, buf_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [2:0]          err_q, err_d;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [31:0]         sum_q, sum_d;
`endif

    logic                stb;
    logic                ack;
    logic                expired;
    logic [31:0]         word;
    logic [CNT_W-1:0]    hdr_cnt;
    logic [ADDR_W-1:0]   hdr_addr;

    assign word     = bus.iUartRx32;
    assign stb      = bus.iWordAvailable & ~avail_q;
    assign hdr_cnt  = word[CNT_MSB:CNT_LSB];
    assign hdr_addr = word[ADDR_W-1:HDR_ADDR_LSB];
    // Ack only counts while a request is actually being presented.
    assign ack      = bus.iMemAck & buf_full_q & (state_q == ST_DATA);

    // Idle time is only charged while the loader waits on the host, never on memory.
    uart_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (iClock),
        .rst      (iReset),
        .clear_i  (stb),
        .enable_i (((state_q == ST_DATA) || (state_q == ST_CHECK)) && !buf_full_q),
        .expired_o(expired)
    );

    always_comb begin
        state_d     = state_q;
        buf_full_d  = buf_full_q;
        buf_d       = buf_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        err_d       = err_q;
`ifdef UART_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (stb) begin
                    addr_d      = hdr_addr;
                    remaining_d = hdr_cnt;
                    buf_full_d  = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d       = '0;
`endif
                    if (hdr_cnt == '0) begin
                        err_d   = ERR_ZERO_COUNT;
                        state_d = ST_ERROR;
                    end else begin
                        err_d   = ERR_NONE;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (ack) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    buf_full_d  = 1'b0;
                end
                if (stb && buf_full_q && !ack) begin
                    err_d   = ERR_OVERRUN;
                    state_d = ST_ERROR;
                end else if (ack && (remaining_q == CNT_W'(1))) begin
`ifdef UART_LOADER_CHECKSUM_EN
                    // A word arriving with the last ack is already the trailer.
                    if (stb) begin
                        if (word == sum_q) begin
                            state_d = ST_DONE;
                        end else begin
                            err_d   = ERR_CHECKSUM;
                            state_d = ST_ERROR;
                        end
                    end else begin
                        state_d = ST_CHECK;
                    end
`else
                    state_d = ST_DONE;
`endif
                end else if (stb) begin
                    buf_full_d = 1'b1;
                    buf_d      = word;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + word;
`endif
                end else if (expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_ERROR;
                end
            end
            ST_CHECK: begin
`ifdef UART_LOADER_CHECKSUM_EN
                if (stb) begin
                    if (word == sum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        err_d   = ERR_CHECKSUM;
                        state_d = ST_ERROR;
                    end
                end else if (expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_ERROR;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE, ST_ERROR: begin
                buf_full_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q     <= ST_IDLE;
            avail_q     <= 1'b0;
            buf_full_q  <= 1'b0;
            buf_q       <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            err_q       <= ERR_NONE;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            avail_q     <= bus.iWordAvailable;
            buf_full_q  <= buf_full_d;
            buf_q       <= buf_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign bus.oMemWriteEnable = buf_full_q && (state_q == ST_DATA);
    assign bus.oMemAddress     = addr_q;
    assign bus.oMemData        = buf_q;
    assign bus.oBusy           = (state_q == ST_DATA) || (state_q == ST_CHECK);
    assign bus.oDone           = (state_q == ST_DONE);
    assign bus.oError          = (state_q == ST_ERROR);
    assign bus.oErrorCode      = err_q;
endmodule

// File: tb/tb_uart_block_loader.sv
// tb/tb_uart_block_loader.sv - self-checking bench for uart_block_loader
module tb_uart_block_loader;
    import uart_loader_pkg::*;

    localparam int AW = 16;
    localparam int CW = 16;
    localparam int TO = 64;
    localparam int NEVER = 100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_block_loader_if #(.ADDR_W(AW)) bus ();

    uart_block_loader #(
        .ADDR_W(AW),
        .CNT_W(CW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .iClock(clk),
        .iReset(rst),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] base;
        int          n;
        int          ad;
        int          gap;
        int          bad;
        bit          exp_done;
        logic [2:0]  exp_code;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    int ack_delay_v = 1;
    int done_cnt = 0;
    int err_cnt = 0;
    int wr_n = 0;
    logic [15:0] wr_addr [512];
    logic [31:0] wr_data [512];

    // Memory side: acks each request after ack_delay_v cycles, and logs accepted writes and pulses.
    initial begin
        int ack_wait;
        ack_wait = 0;
        bus.iMemAck = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.oMemWriteEnable && ack_wait >= ack_delay_v) begin
                bus.iMemAck = 1'b1;
                ack_wait = 0;
            end else begin
                bus.iMemAck = 1'b0;
                ack_wait = bus.oMemWriteEnable ? ack_wait + 1 : 0;
            end
            #1;
            if (bus.oMemWriteEnable && bus.iMemAck && wr_n < 512) begin
                wr_addr[wr_n] = bus.oMemAddress;
                wr_data[wr_n] = bus.oMemData;
                wr_n++;
            end
            if (bus.oDone) done_cnt++;
            if (bus.oError) err_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int hold, input int gap);
        @(negedge clk);
        bus.iUartRx32 = w;
        bus.iWordAvailable = 1'b1;
        repeat (hold) @(negedge clk);
        bus.iWordAvailable = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_end(input int budget, input int d0, input int e0, input string name);
        int k;
        k = 0;
        while (done_cnt == d0 && err_cnt == e0 && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (done_cnt == d0 && err_cnt == e0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no done/error within %0d cycles", name, budget);
        end
    endtask

    // Reference: every payload word i lands at (base+i) mod 2^16 in order; outcome given by caller.
    task automatic run_packet(input string name, input logic [15:0] base, input int n, input int ad,
                              input int gap, input int bad, input bit exp_done, input logic [2:0] exp_code);
        logic [31:0] data [$];
        logic [31:0] sum;
        int d0, e0, w0, got;
        ack_delay_v = ad;
        d0 = done_cnt; e0 = err_cnt; w0 = wr_n;
        sum = 32'd0;
        for (int i = 0; i < n; i++) begin
            data.push_back($urandom);
            sum = sum + data[i];
        end
        send_word({16'(n), base}, 2, gap);
        for (int i = 0; i < n; i++) send_word(data[i], 2, gap);
`ifdef UART_LOADER_CHECKSUM_EN
        if (n > 0) send_word(sum + 32'(bad), 2, gap);
`endif
        wait_end(200, d0, e0, name);
        got = wr_n - w0;
        check({name, " done pulses"}, 32'(done_cnt - d0), exp_done ? 32'd1 : 32'd0);
        check({name, " error pulses"}, 32'(err_cnt - e0), exp_done ? 32'd0 : 32'd1);
        check({name, " error code"}, 32'(bus.oErrorCode), 32'(exp_code));
        check({name, " write count"}, 32'(got), 32'(n));
        for (int i = 0; i < n && i < got; i++) begin
            check({name, " addr"}, 32'(wr_addr[w0 + i]), 32'(16'(32'(base) + i)));
            check({name, " data"}, wr_data[w0 + i], data[i]);
        end
        @(negedge clk);
        #2;
        check({name, " busy after end"}, 32'(bus.oBusy), 32'd0);
    endtask

    initial begin
        vec_t vecs [$];
        int d0, e0, w0;
        logic [31:0] w1, w2;

        bus.iWordAvailable = 1'b0;
        bus.iUartRx32 = 32'd0;

        repeat (3) @(negedge clk);
        check("reset we", 32'(bus.oMemWriteEnable), 32'd0);
        check("reset busy", 32'(bus.oBusy), 32'd0);
        check("reset done", 32'(bus.oDone), 32'd0);
        check("reset error", 32'(bus.oError), 32'd0);
        check("reset code", 32'(bus.oErrorCode), 32'd0);
        check("reset addr", 32'(bus.oMemAddress), 32'd0);
        check("reset data", bus.oMemData, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        vecs.push_back('{16'h0100, 3, 1, 3, 0, 1'b1, ERR_NONE});
        vecs.push_back('{16'h1234, 0, 1, 3, 0, 1'b0, ERR_ZERO_COUNT});
        vecs.push_back('{16'h0000, 1, 0, 2, 0, 1'b1, ERR_NONE});
        vecs.push_back('{16'h7FFE, 4, 2, 4, 0, 1'b1, ERR_NONE});
        vecs.push_back('{16'hFFFE, 3, 0, 2, 0, 1'b1, ERR_NONE});
        vecs.push_back('{16'h0042, 5, 3, 5, 0, 1'b1, ERR_NONE});
`ifdef UART_LOADER_CHECKSUM_EN
        vecs.push_back('{16'h0200, 2, 1, 3, 1, 1'b0, ERR_CHECKSUM});
        vecs.push_back('{16'h0300, 1, 0, 2, 0, 1'b1, ERR_NONE});
`endif
        foreach (vecs[i])
            run_packet("table", vecs[i].base, vecs[i].n, vecs[i].ad, vecs[i].gap, vecs[i].bad,
                       vecs[i].exp_done, vecs[i].exp_code);

        // Timeout: one payload word of two, then silence.
        ack_delay_v = 1;
        d0 = done_cnt; e0 = err_cnt; w0 = wr_n;
        w1 = $urandom;
        send_word({16'd2, 16'h0400}, 2, 0);
        send_word(w1, 2, 0);
        repeat (TO - 8) @(negedge clk);
        #2;
        check("timeout not early", 32'(err_cnt - e0), 32'd0);
        check("timeout busy while waiting", 32'(bus.oBusy), 32'd1);
        wait_end(40, d0, e0, "timeout");
        check("timeout error pulses", 32'(err_cnt - e0), 32'd1);
        check("timeout done pulses", 32'(done_cnt - d0), 32'd0);
        check("timeout code", 32'(bus.oErrorCode), 32'(ERR_TIMEOUT));
        check("timeout writes", 32'(wr_n - w0), 32'd1);
        check("timeout addr", 32'(wr_addr[w0]), 32'h0400);
        check("timeout data", wr_data[w0], w1);

        // Overrun: memory never acks, second word edge hits a full buffer.
        ack_delay_v = NEVER;
        d0 = done_cnt; e0 = err_cnt; w0 = wr_n;
        send_word({16'd3, 16'h0500}, 2, 2);
        send_word($urandom, 2, 2);
        #2;
        check("overrun request pending", 32'(bus.oMemWriteEnable), 32'd1);
        send_word($urandom, 2, 0);
        wait_end(20, d0, e0, "overrun");
        check("overrun error pulses", 32'(err_cnt - e0), 32'd1);
        check("overrun code", 32'(bus.oErrorCode), 32'(ERR_OVERRUN));
        check("overrun writes", 32'(wr_n - w0), 32'd0);
        @(negedge clk);
        #2;
        check("overrun request dropped", 32'(bus.oMemWriteEnable), 32'd0);

        // Address wrap with a word level held high for 50 cycles.
        ack_delay_v = 1;
        d0 = done_cnt; e0 = err_cnt; w0 = wr_n;
        w1 = $urandom;
        w2 = $urandom;
        send_word({16'd2, 16'hFFFF}, 2, 2);
        send_word(w1, 50, 2);
        send_word(w2, 2, 2);
`ifdef UART_LOADER_CHECKSUM_EN
        send_word(w1 + w2, 2, 2);
`endif
        wait_end(100, d0, e0, "wrap");
        check("wrap done pulses", 32'(done_cnt - d0), 32'd1);
        check("wrap error pulses", 32'(err_cnt - e0), 32'd0);
        check("wrap writes", 32'(wr_n - w0), 32'd2);
        check("wrap addr0", 32'(wr_addr[w0]), 32'h0000FFFF);
        check("wrap data0", wr_data[w0], w1);
        check("wrap addr1", 32'(wr_addr[w0 + 1]), 32'h00000000);
        check("wrap data1", wr_data[w0 + 1], w2);

        // Reset in the middle of a packet with a request outstanding.
        ack_delay_v = NEVER;
        d0 = done_cnt; e0 = err_cnt; w0 = wr_n;
        send_word({16'd3, 16'h0600}, 2, 1);
        send_word($urandom, 2, 1);
        #2;
        check("midreset request before", 32'(bus.oMemWriteEnable), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset request dropped", 32'(bus.oMemWriteEnable), 32'd0);
        check("midreset busy", 32'(bus.oBusy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_delay_v = 1;
        repeat (10) @(negedge clk);
        #2;
        check("midreset done pulses", 32'(done_cnt - d0), 32'd0);
        check("midreset error pulses", 32'(err_cnt - e0), 32'd0);
        check("midreset writes", 32'(wr_n - w0), 32'd0);
        check("midreset code", 32'(bus.oErrorCode), 32'd0);

        // Randomized packets against the outcome model.
        for (int r = 0; r < 12; r++) begin
            int n, ad, gap, bad;
            bit exp_done;
            logic [2:0] exp_code;
            n = $urandom_range(0, 6);
            ad = $urandom_range(0, 3);
            gap = ad + $urandom_range(2, 6);
            bad = 0;
`ifdef UART_LOADER_CHECKSUM_EN
            bad = $urandom_range(0, 1);
`endif
            if (n == 0) begin
                exp_done = 1'b0;
                exp_code = ERR_ZERO_COUNT;
            end else if (bad != 0) begin
                exp_done = 1'b0;
                exp_code = ERR_CHECKSUM;
            end else begin
                exp_done = 1'b1;
                exp_code = ERR_NONE;
            end
            run_packet("random", 16'($urandom), n, ad, gap, bad, exp_done, exp_code);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
